// File: rtl/sync_fifo_vr.sv
// sync_fifo_vr: synchronous FIFO with valid/ready on both ports.
// Storage is a register array. Pointers carry an extra wrap bit, so full and
// empty can be told apart without a separate counter. The level counter is
// kept as its own register so that level_o and the threshold flags come
// straight from state. The read port is first-word fall-through.
module sync_fifo_vr #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH-2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     s_valid_i,
  input  logic [DATA_WIDTH-1:0]    s_data_i,
  output logic                     s_ready_o,
  output logic                     m_valid_o,
  output logic [DATA_WIDTH-1:0]    m_data_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     afull_o,
  output logic                     aempty_o,
  output logic                     ovf_o,
  output logic                     udf_o,
  input  logic                     clr_err_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AEMPTY_THRESH);

  // Occupancy class, decoded from the pointers rather than held in a register.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [PW-1:0]         level;
  occ_e                  occ;
  logic                  empty, full;
  logic                  push, pop;

  // Pointers equal -> empty; same index with opposite wrap bit -> full.
  always_comb begin
    occ = OCC_PARTIAL;
    if (wptr == rptr)
      occ = OCC_EMPTY;
    else if ((wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]))
      occ = OCC_FULL;
  end

  assign empty = (occ == OCC_EMPTY);
  assign full  = (occ == OCC_FULL);

  // Handshakes. s_ready depends only on state, so a pop while full does not
  // open the write port in the same cycle.
  assign s_ready_o = !full;
  assign m_valid_o = !empty;
  assign push      = s_valid_i && s_ready_o;
  assign pop       = m_valid_o && m_ready_i;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= s_data_i;
  end

  assign m_data_o = mem[rptr[AW-1:0]];

  // Pointer advance, modulo 2*DEPTH through natural wrap of PW bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Occupancy counter: +1 on lone push, -1 on lone pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level <= level + PW'(1);
        2'b01:   level <= level - PW'(1);
        default: level <= level;
      endcase
    end
  end

  assign level_o  = level;
  assign afull_o  = (level >= AF_LVL);
  assign aempty_o = (level <= AE_LVL);

  // Sticky error flags; a new event outranks a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      if (s_valid_i && full) ovf_o <= 1'b1;
      else if (clr_err_i)    ovf_o <= 1'b0;
      if (m_ready_i && empty) udf_o <= 1'b1;
      else if (clr_err_i)     udf_o <= 1'b0;
    end
  end

  // Counter and pointers must never disagree.
  a_level_ptr : assert property (@(posedge clk_i) disable iff (!rst_ni)
    level == PW'(wptr - rptr));
  a_level_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
    level <= PW'(DEPTH));

endmodule

// File: tb/tb_sync_fifo_vr.sv
// Bench for sync_fifo_vr: queue-based reference model checked on every
// falling edge, plus directed literal expectations for the key scenarios.
module tb_sync_fifo_vr;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [LW-1:0] level;
  logic          afull, aempty, ovf, udf;
  logic          clr_err = 1'b0;

  int compared = 0;
  int mismatched = 0;

  sync_fifo_vr #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready),
    .level_o(level), .afull_o(afull), .aempty_o(aempty),
    .ovf_o(ovf), .udf_o(udf), .clr_err_i(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus the two sticky flags.
  logic [DW-1:0] q[$];
  bit m_ovf = 0, m_udf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      bit do_push, do_pop;
      do_push = s_valid && (q.size() < DEPTH);
      do_pop  = m_ready && (q.size() > 0);
      if (s_valid && q.size() == DEPTH) m_ovf = 1;
      else if (clr_err) m_ovf = 0;
      if (m_ready && q.size() == 0) m_udf = 1;
      else if (clr_err) m_udf = 0;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(s_data);
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    int n;
    n = q.size();
    check("level", int'(level), n);
    check("s_ready", int'(s_ready), int'(n < DEPTH));
    check("m_valid", int'(m_valid), int'(n > 0));
    check("afull", int'(afull), int'(n >= DEPTH-2));
    check("aempty", int'(aempty), int'(n <= 2));
    check("ovf", int'(ovf), int'(m_ovf));
    check("udf", int'(udf), int'(m_udf));
    if (n > 0) check("m_data", int'(m_data), int'(q[0]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 0; m_ready = 0; clr_err = 0;
  endtask

  initial begin
    int pushed, popped, cycles;
    void'($urandom(32'd1234));

    // reset and release
    cyc(); cyc();
    check("rst_level", int'(level), 0);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_aempty", int'(aempty), 1);
    check("rst_afull", int'(afull), 0);
    rst_n = 1;
    cyc();

    // fill 0x01..0x08 with consumer stalled
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1; s_data = DW'(i);
      cyc();
      check("fill_level", int'(level), i);
      check("fill_afull", int'(afull), int'(i >= 6));
      check("fill_s_ready", int'(s_ready), int'(i < 8));
    end

    // overflow: keep pushing 0xAA while full
    s_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ovf_set", int'(ovf), 1);
      check("ovf_level", int'(level), 8);
    end
    idle();

    // drain, expecting 0x01..0x08 in order
    for (int i = 1; i <= 8; i++) begin
      check("drain_data", int'(m_data), i);
      m_ready = 1;
      cyc();
    end
    m_ready = 0;
    check("drain_m_valid", int'(m_valid), 0);
    check("drain_udf", int'(udf), 0);

    // underflow then clear
    m_ready = 1; cyc(); m_ready = 0;
    check("udf_set", int'(udf), 1);
    check("ovf_held", int'(ovf), 1);
    clr_err = 1; cyc(); clr_err = 0;
    check("clr_ovf", int'(ovf), 0);
    check("clr_udf", int'(udf), 0);

    // clear and new event in the same cycle: set wins
    m_ready = 1; clr_err = 1; cyc(); idle();
    check("set_wins", int'(udf), 1);
    clr_err = 1; cyc(); idle();

    // level 4 streaming: push+pop for 20 cycles
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = DW'(8'h10 + i); cyc();
    end
    for (int i = 0; i < 20; i++) begin
      check("stream_data", int'(m_data), 8'h10 + i);
      s_valid = 1; m_ready = 1; s_data = DW'(8'h14 + i);
      cyc();
      check("stream_level", int'(level), 4);
    end
    idle();

    // full with push and pop together: only the pop happens
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = DW'(8'h40 + i); cyc();
    end
    s_valid = 0;
    check("full_level", int'(level), 8);
    s_valid = 1; m_ready = 1; s_data = 8'h55; cyc(); idle();
    check("full_pushpop_level", int'(level), 7);
    check("full_pushpop_ovf", int'(ovf), 1);

    // reset mid-stream with 3 words stored
    rst_n = 0; cyc(); rst_n = 1; cyc();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_data = DW'(8'h60 + i); cyc();
    end
    idle();
    check("pre_rst_level", int'(level), 3);
    #2 rst_n = 0;
    #1;
    check("async_rst_level", int'(level), 0);
    check("async_rst_m_valid", int'(m_valid), 0);
    check("async_rst_s_ready", int'(s_ready), 1);
    check("async_rst_aempty", int'(aempty), 1);
    check("async_rst_ovf", int'(ovf), 0);
    check("async_rst_udf", int'(udf), 0);
    cyc(); rst_n = 1; cyc();

    // wrap-around: 40 words through random valid/ready
    pushed = 0; popped = 0; cycles = 0;
    while ((pushed < 40 || popped < 40) && cycles < 2000) begin
      bit wp, rp;
      s_valid = (pushed < 40) && ($urandom_range(0, 3) != 0);
      s_data  = DW'(8'h80 + pushed);
      m_ready = ($urandom_range(0, 2) != 0);
      wp = s_valid && s_ready;
      rp = m_ready && m_valid;
      if (rp) check("wrap_order", int'(m_data), 8'h80 + popped);
      cyc();
      if (wp) pushed++;
      if (rp) popped++;
      cycles++;
    end
    idle();
    check("wrap_pushed", pushed, 40);
    check("wrap_popped", popped, 40);
    check("wrap_empty", int'(m_valid), 0);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sync_fifo_vr.md
# sync_fifo_vr

Parameterisable synchronous FIFO with valid/ready handshakes on both sides. It is the first DUT the base verification environment drives: the test's driver pushes words through the virtual interface into the write port, and the monitor drains the read port. Status outputs (level, almost-full/empty, sticky error flags) let the scoreboard check occupancy every cycle.

## Interface
- DATA_WIDTH, 8, width of each stored word
- DEPTH, 8, number of entries; power of two, at least 2
- AFULL_THRESH, DEPTH-2, `afull_o` is high when level >= this value
- AEMPTY_THRESH, 2, `aempty_o` is high when level <= this value
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- s_valid_i  in  1  write request
- s_data_i  in  DATA_WIDTH  write data
- s_ready_o  out  1  FIFO can accept a word (not full)
- m_valid_o  out  1  read data is valid (not empty)
- m_data_o  out  DATA_WIDTH  head-of-FIFO word
- m_ready_i  in  1  consumer accepts the head word
- level_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- afull_o  out  1  almost-full flag
- aempty_o  out  1  almost-empty flag
- ovf_o  out  1  sticky: a write was attempted while full
- udf_o  out  1  sticky: a read was attempted while empty
- clr_err_i  in  1  synchronous clear of `ovf_o` and `udf_o`

## Operation
- Storage: register array of DEPTH x DATA_WIDTH words.
- Write and read pointers are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit. The array index is the lower bits.
- Empty when the pointers are equal. Full when the lower bits are equal and the wrap bits differ.
- Write handshake: a push happens when s_valid_i && s_ready_o. The word goes into mem[wptr] and wptr increments modulo 2*DEPTH.
- Read handshake: a pop happens when m_valid_o && m_ready_i. rptr increments modulo 2*DEPTH.
- m_data_o = mem[rptr] (first-word fall-through, combinational from the array). It is don't-care while m_valid_o = 0; the bench must not check it then.
- Simultaneous push and pop:
  - Not empty and not full: both happen and level is unchanged.
  - Full: only the pop happens. s_ready_o is low in that cycle, so there is no bypass and no same-cycle ready.
  - Empty: only the push happens, because m_valid_o is low.
- level_o: a registered counter. It is +1 on push only, -1 on pop only, unchanged otherwise. It must always equal wptr - rptr (checked by assertion).
- Flags: s_ready_o = !full, m_valid_o = !empty, afull_o = (level_o >= AFULL_THRESH), aempty_o = (level_o <= AEMPTY_THRESH). All are combinational from registered state.
- ovf_o is set on s_valid_i && full.
- udf_o is set on m_ready_i && empty.
- Both error flags stay set until clr_err_i or reset. If clr_err_i and a new error event occur in the same cycle, the set wins.
- Control state: one implicit state per occupancy class, EMPTY / PARTIAL / FULL, derived from the pointers. No separate FSM register.
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL when a push brings level to DEPTH without a pop.
  - PARTIAL -> EMPTY when a pop brings level to 0 without a push.
  - FULL -> PARTIAL on pop.

## Timing
- Reset (rst_ni low, asynchronous) clears:
  - wptr = rptr = 0 and level_o = 0
  - s_ready_o = 1, m_valid_o = 0
  - aempty_o = 1, afull_o = 0
  - ovf_o = 0, udf_o = 0
- Array contents are not reset.
- Reset deassertion is synchronised externally. The first handshake can be accepted on the first rising edge after rst_ni goes high.
- Write-to-read latency: a word pushed at edge N is visible on m_data_o, with m_valid_o = 1, immediately after edge N (1-cycle latency).
- Throughput: one push and one pop per cycle, sustained.
- Reset mid-operation: all buffered words are discarded. Outputs return to reset values asynchronously within the same cycle.
- Pointer wrap: after 2*DEPTH pushes, wptr returns to 0 and ordering is preserved across the wrap.

## Test plan
- **Reset values:** assert rst_ni low mid-stream with 3 words stored -> immediately level_o = 0, m_valid_o = 0, s_ready_o = 1, aempty_o = 1, ovf_o = 0, udf_o = 0.
- **Fill and drain (DEPTH = 8):**
  - Push 0x01..0x08 with m_ready_i = 0 -> level_o counts 1..8, afull_o rises at level 6, s_ready_o = 0 at level 8.
  - Then pop all -> data out 0x01..0x08 in order, m_valid_o = 0 after the 8th pop.
- **Overflow/underflow:**
  - While full, hold s_valid_i = 1 with data 0xAA -> ovf_o = 1, level stays 8, and 0xAA never appears on output.
  - While empty, assert m_ready_i -> udf_o = 1.
  - Pulse clr_err_i -> both flags return to 0.
- **Simultaneous push/pop:**
  - At level 4, push and pop every cycle for 20 cycles -> level_o stays 4 and output order matches the input order.
  - At level 8, assert push and pop together -> only the pop happens and level_o = 7.
- **Wrap-around:** 40 pushes and pops with random valid/ready (seeded) -> the scoreboard sees every word exactly once, in order, and level_o always equals the reference-model count.
